// File: rtl/i2c_addr_matcher.sv
// Passive I2C monitor: detects START/STOP, captures the address byte and flags match/NACK in the ACK slot.
// Latency: pin change to internal event SYNC_STAGES+1 clk; event to registered pulse/state update +1 clk.
// Backpressure: none, purely observational; every output is a registered pulse or registered status.
module i2c_addr_matcher #(
  parameter int unsigned            ADDR_WIDTH  = 7,
  parameter logic [ADDR_WIDTH-1:0]  MATCH_ADDR  = 7'h2A,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK   = 7'h7F,
  parameter int unsigned            RW_MODE     = 2,
  parameter int unsigned            SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  match,
  output logic                  nack,
  output logic                  rw,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [3:0]            bit_cnt,
  output logic [2:0]            state_o,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_RW   = 3'd2,
    ST_ACK  = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

  localparam logic [3:0] CNT_ADDR = 4'(ADDR_WIDTH);
  localparam logic [3:0] CNT_MAX  = 4'(ADDR_WIDTH + 2);

  logic [1:0]             rst_sync_q;
  logic                   rst;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_cur, sda_cur;
  logic                   scl_rise, scl_hi, start_ev, stop_ev;
  logic                   rise_q, start_q, stop_q, bit_q;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_sh_q, addr_sh_d;
  logic [3:0]             cnt_q, cnt_d, cnt_inc;
  logic                   rw_bit_q, rw_bit_d;
  logic                   busy_q, busy_d;
  logic                   start_p_q, start_p_d, stop_p_q, stop_p_d;
  logic                   match_p_q, match_p_d, nack_p_q, nack_p_d;
  logic                   addr_ok, rw_ok;

  // Reset asserts immediately but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // Synchronisers plus history flop; idle-high reset so release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_cur;
      sda_hist_q <= sda_cur;
    end
  end

  assign scl_cur  = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur  = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_cur & ~scl_hist_q;
  // Requiring SCL high in both samples makes a simultaneous SCL/SDA edge a data bit.
  assign scl_hi   = scl_cur & scl_hist_q;
  assign start_ev = scl_hi & sda_hist_q & ~sda_cur;
  assign stop_ev  = scl_hi & ~sda_hist_q & sda_cur;

  // Register the decoded bus events so the FSM sees one clean event per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      rise_q  <= scl_rise;
      start_q <= start_ev;
      stop_q  <= stop_ev;
      bit_q   <= sda_cur;
    end
  end

  assign addr_ok = ((addr_sh_q ^ MATCH_ADDR) & ADDR_MASK) == '0;
  assign rw_ok   = (RW_MODE == 0) ? ~bit_q :
                   (RW_MODE == 1) ?  bit_q : 1'b1;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;

  // Frame FSM: START/STOP override everything, otherwise advance on SCL rising edges.
  always_comb begin
    state_d   = state_q;
    addr_sh_d = addr_sh_q;
    cnt_d     = cnt_q;
    rw_bit_d  = rw_bit_q;
    busy_d    = busy_q;
    start_p_d = 1'b0;
    stop_p_d  = 1'b0;
    match_p_d = 1'b0;
    nack_p_d  = 1'b0;
    if (start_q) begin
      start_p_d = 1'b1;
      cnt_d     = 4'd0;
      addr_sh_d = '0;
      busy_d    = 1'b1;
      state_d   = ST_ADDR;
    end else if (stop_q) begin
      stop_p_d  = 1'b1;
      cnt_d     = 4'd0;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end else if (rise_q) begin
      unique case (state_q)
        ST_ADDR: begin
          addr_sh_d = ADDR_WIDTH'({addr_sh_q, bit_q});
          cnt_d     = cnt_inc;
          if (cnt_q + 4'd1 == CNT_ADDR) state_d = ST_RW;
        end
        ST_RW: begin
          rw_bit_d = bit_q;
          cnt_d    = cnt_inc;
          state_d  = (addr_ok && rw_ok) ? ST_ACK : ST_SKIP;
        end
        ST_ACK: begin
          cnt_d     = cnt_inc;
          match_p_d = ~bit_q;
          nack_p_d  = bit_q;
          state_d   = ST_SKIP;
        end
        default: ;
      endcase
    end
  end

  // FSM state, captured fields and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_sh_q <= '0;
      cnt_q     <= 4'd0;
      rw_bit_q  <= 1'b0;
      busy_q    <= 1'b0;
      start_p_q <= 1'b0;
      stop_p_q  <= 1'b0;
      match_p_q <= 1'b0;
      nack_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_sh_q <= addr_sh_d;
      cnt_q     <= cnt_d;
      rw_bit_q  <= rw_bit_d;
      busy_q    <= busy_d;
      start_p_q <= start_p_d;
      stop_p_q  <= stop_p_d;
      match_p_q <= match_p_d;
      nack_p_q  <= nack_p_d;
    end
  end

  assign start_det = start_p_q;
  assign stop_det  = stop_p_q;
  assign match     = match_p_q;
  assign nack      = nack_p_q;
  assign rw        = rw_bit_q;
  assign addr_q    = addr_sh_q;
  assign bit_cnt   = cnt_q;
  assign state_o   = state_q;
  assign busy      = busy_q;

endmodule

// File: doc/i2c_addr_matcher.md
Name: i2c_addr_matcher

Overview:
- Passive, clocked I2C bus monitor. Oversamples SCL/SDA, detects START, repeated START and STOP, shifts in the address byte, and compares it against a parameterised address with a per-bit don't-care mask.
- Observes the ACK slot and flags match/NACK.
- Next-generation replacement for the hard-coded, unclocked bit-pattern FSMs in the bus-sniffer chain. Feeds the capture/trigger logic downstream.

Parameters:
ADDR_WIDTH, 7, number of address bits before the R/W bit (7 or 10-bit first-byte use: 1..8 legal)
MATCH_ADDR, 7'h2A, address to match, MSB first on the bus
ADDR_MASK, 7'h7F, per-bit compare enable; 1 = compare, 0 = don't care
RW_MODE, 2, 0 = match writes only, 1 = reads only, 2 = either
SYNC_STAGES, 2, synchroniser flops on scl/sda (>=2)

Ports:
clk  input  1  system clock, must be >= 8x SCL rate
reset  input  1  asynchronous, active-high reset
scl  input  1  raw bus SCL (asynchronous)
sda  input  1  raw bus SDA (asynchronous)
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
match  output  1  one-cycle pulse: address+R/W matched and ACK seen
nack  output  1  one-cycle pulse: address+R/W matched but ACK slot high
rw  output  1  captured R/W bit of the current frame (1 = read)
addr_q  output  ADDR_WIDTH  captured address of the current frame
bit_cnt  output  4  bits sampled in the current address byte, 0..ADDR_WIDTH+2
state_o  output  3  current FSM state code
busy  output  1  high from START until STOP

Behaviour:
- Reset (async assert, sync release to clk) puts all outputs at 0 and the FSM in IDLE. Assertion mid-frame aborts the frame immediately; no pulse is emitted.
- Input path:
  - scl and sda each pass through SYNC_STAGES flops, then one history flop.
  - Event latency from pin to detection is SYNC_STAGES+1 clk. All pulses are registered one further cycle.
- Edge and condition rules (on synchronised signals):
  - scl_rise = scl 0->1.
  - START = sda 1->0 while scl==1 in both current and previous samples.
  - STOP = sda 0->1 under the same scl condition.
  - If an scl edge and an sda edge land in the same sample, the event is treated as a data bit, not START/STOP.
- FSM states (state_o code):
  - IDLE(0): wait for START.
  - ADDR(1): on each scl_rise, shift sda into addr_q (MSB first) and increment bit_cnt. After ADDR_WIDTH bits -> RW.
  - RW(2): on scl_rise, capture rw, bit_cnt++, evaluate the comparison -> ACK if matched, else SKIP.
  - ACK(3): on scl_rise, bit_cnt++. If sda==0, pulse match; else pulse nack. Then -> SKIP.
  - SKIP(4): ignore data bytes until START or STOP.
- Match rule: ((addr_q ^ MATCH_ADDR) & ADDR_MASK) == 0, and the rw condition per RW_MODE holds.
- START in any state (including repeated START mid-byte or in ACK):
  - pulse start_det, clear bit_cnt, clear addr_q, go to ADDR, set busy.
  - Any partial frame is discarded with no match/nack.
- STOP in any state:
  - pulse stop_det, go to IDLE, clear busy and bit_cnt.
  - addr_q and rw hold their last values until the next START.
- STOP seen in IDLE: stop_det still pulses; busy stays 0.
- match and nack are mutually exclusive and fire at most once per frame.
- bit_cnt saturates at ADDR_WIDTH+2. It never wraps.
- scl_rise in IDLE (no START) is ignored.

Test Plan:
- Write to 0x2A (START, bits 0101010, R/W=0, ACK low, STOP) -> start_det pulse; match pulse SYNC_STAGES+2 clk after the 9th SCL rise; addr_q=0x2A; rw=0; stop_det pulse; busy 1->0.
- Address 0x2B with ADDR_MASK=7'h7E, read, ACK high -> nack pulse only; rw=1; no match. With ADDR_MASK=7'h7F -> neither pulse, state_o=4 until STOP.
- RW_MODE=0 with a read to 0x2A -> no match/nack. Same frame as a write -> match.
- Repeated START after 4 address bits, then a full 0x2A write -> exactly one start_det per START; bit_cnt returns to 0; single match for the second frame.
- Assert reset during bit 5 of an address -> all outputs 0 within the same cycle, state_o=0. The following full frame matches normally.
- SDA toggling while SCL low across 3 data bytes after a match -> no START/STOP pulses, no further match; STOP returns to IDLE.
